// File: rtl/booth_mul_seq_if.sv
// Request/response bundle between the EX-stage issue logic and the sequential Booth multiplier.
// The master starts and cancels operations; the slave returns stall/busy/done and the product.
interface booth_mul_seq_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             stall;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, abort, a, b,
        input  stall, busy, done, hi, lo
    );

    modport slave (
        input  start, abort, a, b,
        output stall, busy, done, hi, lo
    );
endinterface

// File: rtl/booth_mul_seq.sv
// Radix-2 Booth multiplier: one add/sub-and-shift step per cycle, WIDTH steps per product.
// Freezes the pipeline through stall and returns a signed 2*WIDTH product on hi/lo.
module booth_mul_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    booth_mul_seq_if.slave  bus
);
    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             state_q, state_d;
    logic [WIDTH:0]     m_q, m_d;
    logic [WIDTH:0]     acc_q, acc_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               qm1_q, qm1_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, done_q;
    logic [WIDTH:0]     sum;
    logic               load;

    // A carries one extra bit so that subtracting M = -2^(WIDTH-1) cannot overflow.
    always_comb begin
        unique case ({q_q[0], qm1_q})
            2'b01:   sum = acc_q + m_q;
            2'b10:   sum = acc_q - m_q;
            default: sum = acc_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        acc_d   = acc_q;
        q_d     = q_q;
        qm1_d   = qm1_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        load    = 1'b0;

        case (state_q)
            StIdle: begin
                if (bus.start && !bus.abort) begin
                    load    = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (bus.abort) begin
                    state_d = StIdle;
                end else begin
                    acc_d = {sum[WIDTH], sum[WIDTH:1]};
                    q_d   = {sum[0], q_q[WIDTH-1:1]};
                    qm1_d = q_q[0];
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = StDone;
                        hi_d    = acc_d[WIDTH-1:0];
                        lo_d    = q_d;
                    end
                end
            end
            StDone: begin
                if (bus.abort) begin
                    state_d = StIdle;
                end else if (bus.start) begin
                    load    = 1'b1;
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (load) begin
            m_d   = {bus.a[WIDTH-1], bus.a};
            acc_d = '0;
            q_d   = bus.b;
            qm1_d = 1'b0;
            cnt_d = CNT_W'(WIDTH);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            m_q     <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            qm1_q   <= qm1_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= (state_d == StRun);
            done_q  <= (state_d == StDone);
        end
    end

    // Stall drops in the DONE cycle so the multiply can retire with hi/lo valid.
    always_comb begin
        bus.stall = (state_q == StRun) | ((state_q != StRun) & bus.start & ~bus.abort);
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule
